// File: rtl/bin2bcd_seq_if.sv
// Handshake/bus bundle between the calculation counter (master) and the
// sequential binary-to-BCD converter (slave).
//   start     master->slave  request a conversion (taken only while ready=1)
//   blank_lz  master->slave  1 = blank leading zero digits (sampled with start)
//   bin_in    master->slave  unsigned binary value (sampled with start)
//   ready     slave->master  1 = converter idle, start will be accepted
//   done      slave->master  one-cycle pulse, bcd_out/ovf updated this cycle
//   ovf       slave->master  1 = last input exceeded 10^DIGITS-1, output saturated
//   bcd_out   slave->master  packed digits, digit i at [4i+3:4i], digit 0 = LSD
interface bin2bcd_seq_if #(
  parameter int BIN_W  = 30,
  parameter int DIGITS = 9
);
  logic                  start;
  logic                  blank_lz;
  logic [BIN_W-1:0]      bin_in;
  logic                  ready;
  logic                  done;
  logic                  ovf;
  logic [4*DIGITS-1:0]   bcd_out;

  modport master (
    output start, blank_lz, bin_in,
    input  ready, done, ovf, bcd_out
  );

  modport slave (
    input  start, blank_lz, bin_in,
    output ready, done, ovf, bcd_out
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: binary count -> packed BCD digits for
// the HEX display rotator. One shift per clock; inputs above 10^DIGITS-1
// skip the shifting and saturate to all 9s with ovf set.
// Ports:
//   CLOCK_50  in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset (outputs -> blank display)
//   bus       slave modport of bin2bcd_seq_if (start/blank_lz/bin_in in,
//             ready/done/ovf/bcd_out out)
module bin2bcd_seq #(
  parameter int BIN_W  = 30,
  parameter int DIGITS = 9
) (
  input  logic          CLOCK_50,
  input  logic          rst_n,
  bin2bcd_seq_if.slave  bus
);

  localparam int SCR_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  function automatic logic [63:0] max_val(input int d);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < d; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0] MAX = max_val(DIGITS);

  // One double-dabble step: +3 on every digit >= 5, then shift {scratch,bin}.
  // A digit is at most 9 before the add, so it never exceeds 12 and nothing
  // carries into the neighbouring digit.
  function automatic logic [SCR_W+BIN_W-1:0] dabble(input logic [SCR_W-1:0] s,
                                                     input logic [BIN_W-1:0] b);
    logic [SCR_W-1:0] a;
    a = s;
    for (int i = 0; i < DIGITS; i++)
      if (a[4*i +: 4] >= 4'd5) a[4*i +: 4] = a[4*i +: 4] + 4'd3;
    return {a, b} << 1;
  endfunction

  // Leading zeros become 4'hF from the top down; digit 0 always stays.
  function automatic logic [SCR_W-1:0] blank_lead(input logic [SCR_W-1:0] d);
    logic [SCR_W-1:0] r;
    logic             lead;
    r    = d;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'hF;
      else                             lead = 1'b0;
    end
    return r;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [SCR_W-1:0] scr_q,   scr_d;
  logic [BIN_W-1:0] bin_q,   bin_d;
  logic             blank_q, blank_d;
  logic             ovfc_q,  ovfc_d;
  logic [SCR_W-1:0] bcd_q,   bcd_d;
  logic             ovf_q,   ovf_d;
  logic             done_q,  done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    scr_d   = scr_q;
    bin_d   = bin_q;
    blank_d = blank_q;
    ovfc_d  = ovfc_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          bin_d   = bus.bin_in;
          blank_d = bus.blank_lz;
          state_d = S_SHIFT;
          if (64'(bus.bin_in) > MAX) begin
            // Saturate up front; a zero count sends SHIFT straight to DONE.
            ovfc_d = 1'b1;
            scr_d  = {DIGITS{4'h9}};
            cnt_d  = '0;
          end else begin
            ovfc_d = 1'b0;
            scr_d  = '0;
            cnt_d  = CNT_W'(BIN_W);
          end
        end
      end
      S_SHIFT: begin
        if (cnt_q != '0) begin
          {scr_d, bin_d} = dabble(scr_q, bin_q);
          cnt_d          = cnt_q - CNT_W'(1);
        end
        // Leave on the last shift (count 1 -> 0) or at once when nothing to shift.
        if (cnt_q <= CNT_W'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        bcd_d   = (blank_q && !ovfc_q) ? blank_lead(scr_q) : scr_q;
        ovf_d   = ovfc_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      scr_q   <= '0;
      bin_q   <= '0;
      blank_q <= 1'b0;
      ovfc_q  <= 1'b0;
      bcd_q   <= {DIGITS{4'hF}};
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      scr_q   <= scr_d;
      bin_q   <= bin_d;
      blank_q <= blank_d;
      ovfc_q  <= ovfc_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus.ready   = (state_q == S_IDLE);
  assign bus.done    = done_q;
  assign bus.ovf     = ovf_q;
  assign bus.bcd_out = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;

  bin2bcd_seq_if #(.BIN_W(30), .DIGITS(9)) bus ();

  bin2bcd_seq #(.BIN_W(30), .DIGITS(9)) dut (
    .CLOCK_50 (clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decimal reference: digits by division, saturation above 999,999,999.
  function automatic logic [35:0] model(input logic [29:0] v, input logic bl, output logic o);
    int unsigned t;
    int          d [9];
    logic [35:0] r;
    bit          lead;
    if (v > 30'd999999999) begin
      o = 1'b1;
      return 36'h999999999;
    end
    o = 1'b0;
    t = 32'(v);
    for (int i = 0; i < 9; i++) begin
      d[i] = int'(t % 10);
      t    = t / 10;
    end
    lead = bl;
    for (int i = 8; i >= 1; i--) begin
      if (lead && d[i] == 0) d[i] = 15;
      else                   lead = 1'b0;
    end
    r = '0;
    for (int i = 0; i < 9; i++) r[4*i +: 4] = 4'(d[i]);
    return r;
  endfunction

  task automatic wait_ready();
    int w;
    w = 0;
    while (!bus.ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", 64'(w < 100), 64'd1);
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.done) cnt++;
    end
  endtask

  task automatic run_conv(input logic [29:0] v, input logic bl, input bit poke);
    logic [35:0] eb;
    logic        eo;
    logic [35:0] held_b;
    logic        held_o;
    bit          stable;
    int          lat;
    int          n;
    int          cnt;
    eb  = model(v, bl, eo);
    lat = eo ? 2 : 31;
    wait_ready();
    held_b = bus.bcd_out;
    held_o = bus.ovf;
    stable = 1'b1;
    bus.start    = 1'b1;
    bus.bin_in   = v;
    bus.blank_lz = bl;
    @(negedge clk);
    // Scramble the inputs: the converter must work from its latched copy.
    bus.start    = 1'b0;
    bus.bin_in   = 30'($urandom);
    bus.blank_lz = ~bl;
    chk("busy", 64'(bus.ready), 64'd0);
    n = 0;
    while (!bus.done && n < 40) begin
      if (bus.bcd_out !== held_b || bus.ovf !== held_o) stable = 1'b0;
      bus.start = (poke && n == 4);
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    chk("latency", 64'(n), 64'(lat));
    chk("bcd", 64'(bus.bcd_out), 64'(eb));
    chk("ovf", 64'(bus.ovf), 64'(eo));
    chk("stable", 64'(stable), 64'd1);
    @(negedge clk);
    chk("done_1cyc", 64'(bus.done), 64'd0);
    chk("bcd_hold", 64'(bus.bcd_out), 64'(eb));
    if (poke) begin
      count_done(40, cnt);
      chk("no_queue", 64'(cnt), 64'd0);
    end
  endtask

  initial begin
    int          n;
    int          t1;
    int          cnt;
    logic [29:0] v;
    n_checks     = 0;
    n_err        = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.bin_in   = '0;
    bus.blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(bus.ready), 64'd1);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_ovf", 64'(bus.ovf), 64'd0);
    chk("rst_bcd", 64'(bus.bcd_out), 64'h0_0000_000F_FFFF_FFFF);
    rst_n = 1'b1;
    @(negedge clk);

    run_conv(30'd0, 1'b0, 1'b0);
    run_conv(30'd0, 1'b1, 1'b0);
    run_conv(30'd123456789, 1'b0, 1'b0);
    run_conv(30'd999999999, 1'b0, 1'b0);
    run_conv(30'd1000000000, 1'b0, 1'b0);
    run_conv(30'd4050, 1'b1, 1'b1);
    run_conv(30'h3FFFFFFF, 1'b1, 1'b0);
    run_conv(30'd100000000, 1'b1, 1'b0);

    // Reset in the middle of a conversion.
    wait_ready();
    bus.start  = 1'b1;
    bus.bin_in = 30'd555;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 64'(bus.ready), 64'd1);
    chk("arst_bcd", 64'(bus.bcd_out), 64'h0_0000_000F_FFFF_FFFF);
    @(negedge clk);
    chk("arst_done", 64'(bus.done), 64'd0);
    chk("arst_bcd2", 64'(bus.bcd_out), 64'h0_0000_000F_FFFF_FFFF);
    rst_n = 1'b1;
    count_done(40, cnt);
    chk("arst_nodone", 64'(cnt), 64'd0);

    // start held high: back-to-back conversions every 32 cycles.
    wait_ready();
    bus.start    = 1'b1;
    bus.bin_in   = 30'd7;
    bus.blank_lz = 1'b0;
    @(negedge clk);
    bus.bin_in = 30'd42;
    n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("hold_lat", 64'(n), 64'd31);
    chk("hold_bcd1", 64'(bus.bcd_out), 64'h7);
    t1 = n;
    @(negedge clk);
    n++;
    while (!bus.done && n < 80) begin
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    chk("hold_period", 64'(n - t1), 64'd32);
    chk("hold_bcd2", 64'(bus.bcd_out), 64'h42);
    @(negedge clk);
    chk("hold_done_1cyc", 64'(bus.done), 64'd0);

    // Randomized values across small, in-range, full-width and boundary ranges.
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0:       v = 30'($urandom_range(0, 9999));
        1:       v = 30'($urandom_range(0, 999999999));
        2:       v = 30'($urandom);
        default: v = 30'($urandom_range(999999990, 1000000009));
      endcase
      run_conv(v, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
